// File: rtl/gray_to_binary_stream.sv
// Gray-to-binary stream decoder with a single output register and an optional
// step checker that classifies each sample against the previous one.
// Build option: define GRAY2BIN_STEP_CHECK_EN to include the step tracker;
// without it dir, step_err and err_count are tied to zero.
module gray_to_binary_stream #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] gray_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] bin_out,
    output logic [1:0]   dir,
    output logic         step_err,
    output logic [7:0]   err_count
);

    logic [W-1:0] bin_dec;
    logic         xfer;
    logic [1:0]   dir_nxt;
    logic         err_nxt;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_dec        = '0;
        bin_dec[W-1]   = gray_in[W-1];
        for (int unsigned k = 1; k < W; k++) begin
            bin_dec[W-1-k] = bin_dec[W-k] ^ gray_in[W-1-k];
        end
    end

`ifdef GRAY2BIN_STEP_CHECK_EN
    typedef enum logic {EMPTY, TRACK} track_state_t;

    track_state_t state, state_nxt;
    logic [W-1:0] prev_gray;
    logic [W-1:0] prev_bin;
    logic [W-1:0] diff;
    logic [4:0]   step_bits;
    logic [7:0]   err_cnt_q;

    // Tracker next state and step classification of the incoming sample.
    always_comb begin
        state_nxt = state;
        dir_nxt   = 2'b00;
        err_nxt   = 1'b0;
        diff      = gray_in ^ prev_gray;
        step_bits = '0;
        for (int unsigned k = 0; k < W; k++) begin
            step_bits = step_bits + {4'b0000, diff[k]};
        end
        if (xfer) begin
            state_nxt = TRACK;
        end
        if (state == TRACK) begin
            if (step_bits == 5'd0) begin
                dir_nxt = 2'b00;
            end else if (step_bits == 5'd1) begin
                // A single Gray bit flip that is not +/-1 in binary is still
                // classed illegal, but it is not a multi-bit step error.
                if (bin_dec == prev_bin + W'(1)) begin
                    dir_nxt = 2'b01;
                end else if (bin_dec == prev_bin - W'(1)) begin
                    dir_nxt = 2'b10;
                end else begin
                    dir_nxt = 2'b11;
                end
            end else begin
                dir_nxt = 2'b11;
                err_nxt = 1'b1;
            end
        end
    end

    // Tracker state, previous sample and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            prev_gray <= '0;
            prev_bin  <= '0;
            err_cnt_q <= '0;
        end else if (xfer) begin
            state     <= state_nxt;
            prev_gray <= gray_in;
            prev_bin  <= bin_dec;
            if (err_nxt && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_count = err_cnt_q;
`else
    assign dir_nxt   = 2'b00;
    assign err_nxt   = 1'b0;
    assign err_count = '0;
`endif

    // Output register: load on transfer, drain when the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir       <= 2'b00;
            step_err  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            bin_out   <= bin_dec;
            dir       <= dir_nxt;
            step_err  <= err_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
